// File: rtl/reduce_wordgate_pipe.sv
// reduce_wordgate_pipe
//   Pipelined reduction gate. Each accepted W-bit word is collapsed to one bit
//   by AND, OR, XOR or NAND, which is selected per word. A per-bit mask
//   replaces non-participating bits with the identity of the selected op.
//   The reduction is a registered FAN-ary tree with LVL = ceil(log_FAN(W))
//   stages (minimum 1). The whole pipeline advances together under a single
//   enable. Bubbles are not collapsed.
//
// Ports
//   clk, rst_b         clock (rising edge), async active-low reset
//   in_valid/in_ready  input handshake; in_ready = out_ready | ~out_valid
//   in_data, in_mask   word to reduce, 1 = bit participates
//   in_op              00 AND, 01 OR, 10 XOR, 11 NAND
//   out_valid/ready    output handshake
//   out_result         reduction result (qualified by out_valid)
//   out_op, out_empty  op of that word, and whether its mask was all zero

// One tree node: base op over FAN children (NAND uses AND; it is inverted later)
module reduce_wordgate_node #(
   parameter int FAN = 4
) (
   input  logic [FAN-1:0] din,
   input  logic [1:0]     op,
   output logic           dout
);
   always_comb begin
      case (op)
         2'b01:   dout = |din;
         2'b10:   dout = ^din;
         default: dout = &din;
      endcase
   end
endmodule

module reduce_wordgate_pipe #(
   parameter int W   = 32,
   parameter int FAN = 4
) (
   input  logic         clk,
   input  logic         rst_b,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   input  logic [W-1:0] in_mask,
   input  logic [1:0]   in_op,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         out_result,
   output logic [1:0]   out_op,
   output logic         out_empty
);
   function automatic int calc_lvl(input int w, input int f);
      int     l;
      longint n;
      l = 0;
      n = 1;
      while (n < longint'(w)) begin
         n = n * f;
         l++;
      end
      if (l < 1) l = 1;
      return l;
   endfunction

   // Node count registered at level k: ceil(W / FAN^(k+1)); k = -1 gives W
   function automatic int nodes_at(input int w, input int f, input int k);
      int n;
      n = w;
      for (int i = 0; i <= k; i++) n = (n + f - 1) / f;
      return n;
   endfunction

   localparam int LVL = calc_lvl(W, FAN);

   logic                  adv;
   logic [LVL-1:0]        vld_pipe_d, vld_pipe_q;
   logic [LVL-1:0][1:0]   op_d, op_q;
   logic [LVL-1:0]        emp_d, emp_q;

   always_comb adv = out_ready | ~vld_pipe_q[LVL-1];

   // Side-band (valid, op, empty) shifts alongside the tree data
   always_comb begin
      vld_pipe_d    = vld_pipe_q;
      op_d          = op_q;
      emp_d         = emp_q;
      vld_pipe_d[0] = in_valid;
      op_d[0]       = in_op;
      emp_d[0]      = ~|in_mask;
      for (int k = 1; k < LVL; k++) begin
         vld_pipe_d[k] = vld_pipe_q[k-1];
         op_d[k]       = op_q[k-1];
         emp_d[k]      = emp_q[k-1];
      end
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         vld_pipe_q <= '0;
         op_q       <= '0;
         emp_q      <= '0;
      end else if (adv) begin
         vld_pipe_q <= vld_pipe_d;
         op_q       <= op_d;
         emp_q      <= emp_d;
      end
   end

   for (genvar k = 0; k < LVL; k++) begin : g_lvl
      localparam int NK = nodes_at(W, FAN, k);
      localparam int IW = nodes_at(W, FAN, k - 1);

      logic [IW-1:0]     src;
      logic [1:0]        src_op;
      logic              ident;
      logic [NK*FAN-1:0] pad;
      logic [NK-1:0]     red;
      logic [NK-1:0]     node_d, node_q;

      if (k == 0) begin : g_src
         // Masked-off bits take the identity before entering the tree
         always_comb begin
            src_op = in_op;
            ident  = ~(in_op[1] ^ in_op[0]);
            src    = (in_data & in_mask) | (~in_mask & {W{ident}});
         end
      end else begin : g_src
         always_comb begin
            src_op = op_q[k-1];
            ident  = ~(op_q[k-1][1] ^ op_q[k-1][0]);
            src    = g_lvl[k-1].node_q;
         end
      end

      // A partial last node sees identity bits in its unused child slots
      always_comb begin
         pad         = {(NK*FAN){ident}};
         pad[IW-1:0] = src;
      end

      for (genvar n = 0; n < NK; n++) begin : g_node
         reduce_wordgate_node #(.FAN(FAN)) u_node (
            .din  (pad[n*FAN +: FAN]),
            .op   (src_op),
            .dout (red[n])
         );
      end

      // NAND inversion happens once, entering the final register
      always_comb begin
         node_d = red;
         if ((k == LVL - 1) && (src_op == 2'b11)) node_d = ~red;
      end

      always_ff @(posedge clk or negedge rst_b) begin
         if (!rst_b)   node_q <= '0;
         else if (adv) node_q <= node_d;
      end
   end

   always_comb begin
      in_ready   = adv;
      out_valid  = vld_pipe_q[LVL-1];
      out_result = g_lvl[LVL-1].node_q[0];
      out_op     = op_q[LVL-1];
      out_empty  = emp_q[LVL-1];
   end
endmodule

// File: tb/tb_reduce_wordgate_pipe.sv
module tb_reduce_wordgate_pipe;
   logic clk = 1'b0;
   logic rst_b;
   always #5 clk = ~clk;

   // a: W=32 FAN=4 (LVL 3)   b: W=5 FAN=2 (LVL 3)   c: W=1 FAN=3 (LVL 1)
   logic        a_iv, a_ir, a_ov, a_or, a_res, a_emp;
   logic [31:0] a_dat, a_msk;
   logic [1:0]  a_op, a_oop;
   logic        b_iv, b_ir, b_ov, b_or, b_res, b_emp;
   logic [4:0]  b_dat, b_msk;
   logic [1:0]  b_op, b_oop;
   logic        c_iv, c_ir, c_ov, c_or, c_res, c_emp;
   logic [0:0]  c_dat, c_msk;
   logic [1:0]  c_op, c_oop;

   reduce_wordgate_pipe #(.W(32), .FAN(4)) u_a (
      .clk(clk), .rst_b(rst_b), .in_valid(a_iv), .in_ready(a_ir), .in_data(a_dat),
      .in_mask(a_msk), .in_op(a_op), .out_valid(a_ov), .out_ready(a_or),
      .out_result(a_res), .out_op(a_oop), .out_empty(a_emp));
   reduce_wordgate_pipe #(.W(5), .FAN(2)) u_b (
      .clk(clk), .rst_b(rst_b), .in_valid(b_iv), .in_ready(b_ir), .in_data(b_dat),
      .in_mask(b_msk), .in_op(b_op), .out_valid(b_ov), .out_ready(b_or),
      .out_result(b_res), .out_op(b_oop), .out_empty(b_emp));
   reduce_wordgate_pipe #(.W(1), .FAN(3)) u_c (
      .clk(clk), .rst_b(rst_b), .in_valid(c_iv), .in_ready(c_ir), .in_data(c_dat),
      .in_mask(c_msk), .in_op(c_op), .out_valid(c_ov), .out_ready(c_or),
      .out_result(c_res), .out_op(c_oop), .out_empty(c_emp));

   int errs   = 0;
   int checks = 0;

   logic [1:0]  t_op  [16];
   logic [31:0] t_dat [16];
   logic [31:0] t_msk [16];
   logic        t_res [16];
   logic        t_emp [16];

   localparam logic [1:0] AND = 2'b00, OR = 2'b01, XOR = 2'b10, NAND = 2'b11;
   localparam logic [31:0] FULL = 32'hFFFF_FFFF;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic set_w(input int i, input logic [1:0] op, input logic [31:0] d,
                        input logic [31:0] m, input logic r, input logic e);
      t_op[i] = op; t_dat[i] = d; t_msk[i] = m; t_res[i] = r; t_emp[i] = e;
   endtask

   task automatic drive(input int sel, input int i, input logic v);
      case (sel)
         0: begin a_iv = v; if (v) begin a_op = t_op[i]; a_dat = t_dat[i]; a_msk = t_msk[i]; end end
         1: begin b_iv = v; if (v) begin b_op = t_op[i]; b_dat = t_dat[i][4:0]; b_msk = t_msk[i][4:0]; end end
         default: begin c_iv = v; if (v) begin c_op = t_op[i]; c_dat = t_dat[i][0:0]; c_msk = t_msk[i][0:0]; end end
      endcase
   endtask

   task automatic get_out(input int sel, output logic ov, output logic res,
                          output logic [1:0] op, output logic emp);
      case (sel)
         0:       begin ov = a_ov; res = a_res; op = a_oop; emp = a_emp; end
         1:       begin ov = b_ov; res = b_res; op = b_oop; emp = b_emp; end
         default: begin ov = c_ov; res = c_res; op = c_oop; emp = c_emp; end
      endcase
   endtask

   task automatic check_out(input int sel, input int j);
      logic ov, res, emp;
      logic [1:0] op;
      get_out(sel, ov, res, op, emp);
      chk($sformatf("d%0d_w%0d_valid", sel, j), 32'(ov), 32'd1);
      chk($sformatf("d%0d_w%0d_result", sel, j), 32'(res), 32'(t_res[j]));
      chk($sformatf("d%0d_w%0d_op", sel, j), 32'(op), 32'(t_op[j]));
      chk($sformatf("d%0d_w%0d_empty", sel, j), 32'(emp), 32'(t_emp[j]));
   endtask

   task automatic check_idle(input int sel, input string tag);
      logic ov, res, emp;
      logic [1:0] op;
      get_out(sel, ov, res, op, emp);
      chk($sformatf("d%0d_%s_idle", sel, tag), 32'(ov), 32'd0);
   endtask

   // Back-to-back stream of n table words with out_ready held high
   task automatic stream(input int n, input int sel);
      int lvl;
      lvl = (sel == 2) ? 1 : 3;
      for (int i = 0; i < n + lvl - 1; i++) begin
         if (i < n) drive(sel, i, 1'b1);
         else       drive(sel, 0, 1'b0);
         wait_edge();
         if (i - (lvl - 1) >= 0) check_out(sel, i - (lvl - 1));
         else                    check_idle(sel, $sformatf("lat%0d", i));
      end
      drive(sel, 0, 1'b0);
      wait_edge();
      check_idle(sel, "drain");
   endtask

   initial begin
      rst_b = 1'b0;
      a_iv = 0; a_dat = '0; a_msk = '0; a_op = '0; a_or = 1'b1;
      b_iv = 0; b_dat = '0; b_msk = '0; b_op = '0; b_or = 1'b1;
      c_iv = 0; c_dat = '0; c_msk = '0; c_op = '0; c_or = 1'b1;
      #2;
      chk("rst_out_valid", 32'(a_ov), 32'd0);
      chk("rst_out_result", 32'(a_res), 32'd0);
      chk("rst_out_op", 32'(a_oop), 32'd0);
      chk("rst_out_empty", 32'(a_emp), 32'd0);
      chk("rst_in_ready", 32'(a_ir), 32'd1);
      chk("rst_b_valid", 32'(b_ov), 32'd0);
      chk("rst_c_valid", 32'(c_ov), 32'd0);
      wait_edge();
      rst_b = 1'b1;

      // Full-mask AND, all ones then one zero bit
      set_w(0, AND, FULL, FULL, 1'b1, 1'b0);
      set_w(1, AND, 32'hFFFF_FFFE, FULL, 1'b0, 1'b0);
      stream(2, 0);

      // One word per op on consecutive cycles
      set_w(0, AND,  32'h1, FULL, 1'b0, 1'b0);
      set_w(1, OR,   32'h1, FULL, 1'b1, 1'b0);
      set_w(2, XOR,  32'h1, FULL, 1'b1, 1'b0);
      set_w(3, NAND, 32'h1, FULL, 1'b1, 1'b0);
      stream(4, 0);

      // Masks, all-masked identities and top-bit patterns
      set_w(0,  AND,  32'h0000_FFFF, 32'h0000_FFFF, 1'b1, 1'b0);
      set_w(1,  XOR,  32'h0000_0007, 32'h0000_0003, 1'b0, 1'b0);
      set_w(2,  NAND, 32'h0,         32'h0,         1'b0, 1'b1);
      set_w(3,  AND,  32'h0,         32'h0,         1'b1, 1'b1);
      set_w(4,  OR,   FULL,          32'h0,         1'b0, 1'b1);
      set_w(5,  XOR,  32'h8000_0000, FULL,          1'b1, 1'b0);
      set_w(6,  AND,  32'h7FFF_FFFF, FULL,          1'b0, 1'b0);
      set_w(7,  NAND, FULL,          FULL,          1'b0, 1'b0);
      set_w(8,  OR,   32'h0,         FULL,          1'b0, 1'b0);
      set_w(9,  XOR,  32'h8000_0001, FULL,          1'b0, 1'b0);
      set_w(10, OR,   32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b0);
      stream(11, 0);

      // Stall: output held for 4 cycles once the first word arrives
      set_w(0, AND,  32'h0, FULL, 1'b0, 1'b0);
      set_w(1, OR,   32'h1, FULL, 1'b1, 1'b0);
      set_w(2, XOR,  32'h3, FULL, 1'b0, 1'b0);
      set_w(3, NAND, 32'h0, FULL, 1'b1, 1'b0);
      set_w(4, XOR,  32'h1, FULL, 1'b1, 1'b0);
      drive(0, 0, 1'b1); wait_edge();
      drive(0, 1, 1'b1); wait_edge();
      drive(0, 2, 1'b1); wait_edge();
      check_out(0, 0);
      a_or = 1'b0;
      drive(0, 3, 1'b1);
      #1;
      chk("stall_in_ready", 32'(a_ir), 32'd0);
      repeat (4) begin
         wait_edge();
         check_out(0, 0);
         chk("stall_in_ready_hold", 32'(a_ir), 32'd0);
      end
      a_or = 1'b1;
      wait_edge(); check_out(0, 1);
      drive(0, 4, 1'b1);
      wait_edge(); check_out(0, 2);
      drive(0, 0, 1'b0);
      wait_edge(); check_out(0, 3);
      wait_edge(); check_out(0, 4);
      wait_edge(); check_idle(0, "stall_done");

      // Asynchronous reset with three words in flight
      set_w(0, AND, FULL, FULL, 1'b1, 1'b0);
      set_w(1, AND, FULL, FULL, 1'b1, 1'b0);
      set_w(2, AND, FULL, FULL, 1'b1, 1'b0);
      drive(0, 0, 1'b1); wait_edge();
      drive(0, 1, 1'b1); wait_edge();
      drive(0, 2, 1'b1); wait_edge();
      drive(0, 0, 1'b0);
      check_out(0, 0);
      #2 rst_b = 1'b0;
      #1;
      chk("async_rst_valid", 32'(a_ov), 32'd0);
      chk("async_rst_result", 32'(a_res), 32'd0);
      wait_edge();
      rst_b = 1'b1;
      for (int i = 0; i < 3; i++) begin
         wait_edge();
         check_idle(0, $sformatf("post_rst%0d", i));
      end
      set_w(0, OR, 32'h1, FULL, 1'b1, 1'b0);
      stream(1, 0);

      // W=5, FAN=2: padded nodes at every level
      set_w(0, XOR,  32'h10, 32'h1F, 1'b1, 1'b0);
      set_w(1, AND,  32'h0F, 32'h0F, 1'b1, 1'b0);
      set_w(2, AND,  32'h0F, 32'h1F, 1'b0, 1'b0);
      set_w(3, OR,   32'h10, 32'h0F, 1'b0, 1'b0);
      set_w(4, NAND, 32'h1F, 32'h1F, 1'b0, 1'b0);
      set_w(5, XOR,  32'h15, 32'h1F, 1'b1, 1'b0);
      set_w(6, OR,   32'h00, 32'h00, 1'b0, 1'b1);
      set_w(7, NAND, 32'h00, 32'h00, 1'b0, 1'b1);
      stream(8, 1);

      // W=1, FAN=3: single stage
      set_w(0, AND,  32'h1, 32'h1, 1'b1, 1'b0);
      set_w(1, AND,  32'h0, 32'h1, 1'b0, 1'b0);
      set_w(2, NAND, 32'h1, 32'h1, 1'b0, 1'b0);
      set_w(3, XOR,  32'h1, 32'h0, 1'b0, 1'b1);
      set_w(4, NAND, 32'h0, 32'h0, 1'b0, 1'b1);
      set_w(5, OR,   32'h1, 32'h1, 1'b1, 1'b0);
      stream(6, 2);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
